// File: rtl/idct2_mul_share_ctrl_if.sv
// idct2_mul_share_ctrl_if: requester, multiplier and response bundle of the shared-multiplier scheduler
interface idct2_mul_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_din0;
  logic [NUM_REQ*8-1:0]  req_din1;
  logic [31:0]           mul_din0;
  logic [7:0]            mul_din1;
  logic                  mul_ce;
  logic [31:0]           mul_dout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic [15:0]           issue_cnt;
  modport master (
    output req_valid, req_din0, req_din1, mul_dout, rsp_ready,
    input  req_ready, mul_din0, mul_din1, mul_ce, rsp_valid, rsp_id, rsp_data, issue_cnt
  );
  modport slave (
    input  req_valid, req_din0, req_din1, mul_dout, rsp_ready,
    output req_ready, mul_din0, mul_din1, mul_ce, rsp_valid, rsp_id, rsp_data, issue_cnt
  );
endinterface

// File: rtl/idct2_mul_share_ctrl.sv
// idct2_mul_share_ctrl: round-robin sharing of one pipelined 32x8 multiplier with id-tagged responses
module idct2_mul_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input logic                  clk,
  input logic                  reset,
  idct2_mul_share_ctrl_if.slave bus
);
  logic [MUL_LAT-1:0]           r_vld;
  logic [MUL_LAT-1:0][ID_W-1:0] r_id;
  logic [ID_W-1:0]              r_ptr;
  logic [15:0]                  r_cnt;
  logic                         w_ce;
  logic                         w_any;
  logic [ID_W-1:0]              w_gid;
  assign w_ce          = ~(r_vld[MUL_LAT-1] & ~bus.rsp_ready);
  assign bus.mul_ce    = w_ce;
  assign bus.rsp_valid = r_vld[MUL_LAT-1];
  assign bus.rsp_id    = r_id[MUL_LAT-1];
  assign bus.rsp_data  = bus.mul_dout;
  assign bus.issue_cnt = r_cnt;
  assign bus.mul_din0  = bus.req_din0[32*w_gid +: 32];
  assign bus.mul_din1  = bus.req_din1[8*w_gid +: 8];
  assign bus.req_ready = (reset && w_any && w_ce) ? NUM_REQ'(1) << w_gid : '0;
  // Round-robin pick: scan from farthest to nearest so the nearest valid requester to r_ptr wins
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [ID_W:0] j;
      j = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (j >= (ID_W+1)'(NUM_REQ)) j = j - (ID_W+1)'(NUM_REQ);
      if (bus.req_valid[j[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_gid = j[ID_W-1:0];
      end
    end
  end
  // Tag pipeline, pointer and issue counter advance in lockstep with the multiplier's ce
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_vld <= '0;
      r_id  <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_ce) begin
      for (int s = MUL_LAT - 1; s > 0; s--) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
      end
      r_vld[0] <= w_any;
      r_id[0]  <= w_gid;
      if (w_any) begin
        r_ptr <= (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
        r_cnt <= r_cnt + 16'd1;
      end
    end
endmodule

// File: tb/tb_idct2_mul_share_ctrl.sv
// tb_idct2_mul_share_ctrl: vectors, hand sequences and a randomized model check for the multiplier scheduler
module tb_idct2_mul_share_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_tot = 0;
  always #5 clk = ~clk;
  idct2_mul_share_ctrl_if #(.NUM_REQ(4), .ID_W(2)) a ();
  idct2_mul_share_ctrl_if #(.NUM_REQ(3), .ID_W(2)) b ();
  idct2_mul_share_ctrl #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  idct2_mul_share_ctrl #(.NUM_REQ(3), .ID_W(2), .MUL_LAT(3)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));
  logic [31:0] ma;
  logic [31:0] mb [3];
  always_ff @(posedge clk)
    if (a.mul_ce) ma <= $signed(a.mul_din0) * $signed({{24{a.mul_din1[7]}}, a.mul_din1});
  always_ff @(posedge clk)
    if (b.mul_ce) begin
      mb[0] <= $signed(b.mul_din0) * $signed({{24{b.mul_din1[7]}}, b.mul_din1});
      mb[1] <= mb[0];
      mb[2] <= mb[1];
    end
  assign a.mul_dout = ma;
  assign b.mul_dout = mb[2];
  typedef struct {
    logic [3:0]  v;
    logic        rr;
    logic [3:0]  rdy;
    logic        ce;
    logic        rv;
    logic [1:0]  rid;
    logic [31:0] rd;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask
  task automatic clear_inputs();
    a.req_valid = '0; a.req_din0 = '0; a.req_din1 = '0; a.rsp_ready = 1'b1;
    b.req_valid = '0; b.req_din0 = '0; b.req_din1 = '0; b.rsp_ready = 1'b1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    int m_ptr, m_cnt, m_id, g, best, d, av, bv;
    bit m_v, e_ce;
    logic [31:0] m_data;
    logic [3:0] e_rdy;
    clear_inputs();
    a.req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(a.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(a.rsp_id), 32'd0);
    chk("rst_mul_ce", 32'(a.mul_ce), 32'd1);
    chk("rst_issue_cnt", 32'(a.issue_cnt), 32'd0);
    chk("rst_req_ready_forced", 32'(a.req_ready), 32'd0);
    a.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    // single requester 2: 1000 * -3
    @(negedge clk);
    a.req_valid = 4'b0100;
    a.req_din0[64 +: 32] = 32'd1000;
    a.req_din1[16 +: 8] = 8'hFD;
    #1;
    chk("t1_req_ready", 32'(a.req_ready), 32'h4);
    @(negedge clk);
    a.req_valid = '0;
    #1;
    chk("t1_rsp_valid", 32'(a.rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(a.rsp_id), 32'd2);
    chk("t1_rsp_data", a.rsp_data, -32'sd3000);
    chk("t1_issue_cnt", 32'(a.issue_cnt), 32'd1);
    // rotation with all valid, then a three-cycle stall with only requester 1 valid
    tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0, 32'd0, 16'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 1'b1, 2'd0, 32'd2, 16'd1};
    tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 1'b1, 2'd1, 32'd4, 16'd2};
    tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 2'd2, 32'd6, 16'd3};
    tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 2'd3, 32'd8, 16'd4};
    tbl[5]  = '{4'hF, 1'b1, 4'h2, 1'b1, 1'b1, 2'd0, 32'd2, 16'd5};
    tbl[6]  = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 32'd4, 16'd6};
    tbl[7]  = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 32'd4, 16'd6};
    tbl[8]  = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 32'd4, 16'd6};
    tbl[9]  = '{4'h2, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 32'd4, 16'd6};
    tbl[10] = '{4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd1, 32'd4, 16'd7};
    tbl[11] = '{4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 32'd0, 16'd7};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a.req_din0[i*32 +: 32] = 32'(i + 1);
      a.req_din1[i*8 +: 8] = 8'd2;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      a.req_valid = tbl[k].v;
      a.rsp_ready = tbl[k].rr;
      #1;
      chk($sformatf("tbl%0d_req_ready", k), 32'(a.req_ready), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d_mul_ce", k), 32'(a.mul_ce), 32'(tbl[k].ce));
      chk($sformatf("tbl%0d_rsp_valid", k), 32'(a.rsp_valid), 32'(tbl[k].rv));
      chk($sformatf("tbl%0d_issue_cnt", k), 32'(a.issue_cnt), 32'(tbl[k].cnt));
      if (tbl[k].rv) begin
        chk($sformatf("tbl%0d_rsp_id", k), 32'(a.rsp_id), 32'(tbl[k].rid));
        chk($sformatf("tbl%0d_rsp_data", k), a.rsp_data, tbl[k].rd);
      end
    end
    // randomized traffic against a slot-level model of the MUL_LAT=1 instance
    do_reset();
    m_ptr = 0; m_cnt = 0; m_v = 0; m_id = 0; m_data = '0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      a.req_valid = 4'($urandom_range(0, 15));
      a.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        a.req_din0[i*32 +: 32] = $urandom;
        a.req_din1[i*8 +: 8] = 8'($urandom);
      end
      #1;
      g = -1; best = 4;
      for (int i = 0; i < 4; i++) begin
        d = (i - m_ptr + 4) % 4;
        if (a.req_valid[i] && d < best) begin best = d; g = i; end
      end
      e_ce = !(m_v && !a.rsp_ready);
      e_rdy = (g >= 0 && e_ce) ? 4'(1 << g) : 4'h0;
      chk($sformatf("rnd%0d_req_ready", c), 32'(a.req_ready), 32'(e_rdy));
      chk($sformatf("rnd%0d_mul_ce", c), 32'(a.mul_ce), 32'(e_ce));
      chk($sformatf("rnd%0d_rsp_valid", c), 32'(a.rsp_valid), 32'(m_v));
      chk($sformatf("rnd%0d_issue_cnt", c), 32'(a.issue_cnt), 32'(m_cnt));
      if (m_v) begin
        chk($sformatf("rnd%0d_rsp_id", c), 32'(a.rsp_id), 32'(m_id));
        chk($sformatf("rnd%0d_rsp_data", c), a.rsp_data, m_data);
      end
      if (e_ce) begin
        m_v = (g >= 0);
        if (g >= 0) begin
          av = $signed(a.req_din0[g*32 +: 32]);
          bv = $signed(a.req_din1[g*8 +: 8]);
          m_id = g;
          m_data = 32'(av * bv);
          m_ptr = (g + 1) % 4;
          m_cnt = (m_cnt + 1) % 65536;
        end
      end
    end
    // MUL_LAT=3 latency with the most negative operand
    do_reset();
    @(negedge clk);
    b.req_valid = 3'b001;
    b.req_din0[31:0] = 32'h8000_0000;
    b.req_din1[7:0] = 8'hFF;
    #1;
    chk("lat_req_ready", 32'(b.req_ready), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      b.req_valid = '0;
      #1;
      chk($sformatf("lat_c%0d_rsp_valid", c), 32'(b.rsp_valid), (c == 3) ? 32'd1 : 32'd0);
    end
    chk("lat_rsp_data", b.rsp_data, 32'h8000_0000);
    chk("lat_rsp_id", 32'(b.rsp_id), 32'd0);
    // three requesters, pointer resumes at 1 and wraps 2 -> 0
    @(negedge clk);
    b.req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("wrap%0d_req_ready", c), 32'(b.req_ready), 32'(3'b001 << ((c + 1) % 3)));
      @(negedge clk);
    end
    // reset pulse with two products in flight and one stalled at the output
    do_reset();
    @(negedge clk);
    b.req_valid = 3'b011;
    b.req_din0[31:0] = 32'd5; b.req_din1[7:0] = 8'd3;
    b.req_din0[63:32] = 32'd7; b.req_din1[15:8] = 8'd2;
    b.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    b.req_valid = '0;
    @(negedge clk);
    #1;
    chk("rp_pre_rsp_valid", 32'(b.rsp_valid), 32'd1);
    chk("rp_pre_rsp_data", b.rsp_data, 32'd15);
    #1;
    reset = 1'b0;
    #1;
    chk("rp_rsp_valid", 32'(b.rsp_valid), 32'd0);
    chk("rp_issue_cnt", 32'(b.issue_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    b.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rp_post%0d_rsp_valid", c), 32'(b.rsp_valid), 32'd0);
      @(negedge clk);
    end
    b.req_valid = 3'b111;
    #1;
    chk("rp_ptr_zero", 32'(b.req_ready), 32'h1);
    @(negedge clk);
    b.req_valid = '0;
    // issue counter wrap after 65536 accepts
    do_reset();
    @(negedge clk);
    a.req_valid = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_ffff", 32'(a.issue_cnt), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    chk("cnt_wrap", 32'(a.issue_cnt), 32'd0);
    a.req_valid = '0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
